// File: rtl/mem_x_arbiter.sv
// Round-robin arbiter sharing one single-port scratch memory among NUM_REQ burst-capable requesters.
// Latency: grant and memory command are combinational in the request cycle; read response one cycle later.
// Backpressure: req_ready is one-hot to the winner or lock owner; all other requesters wait with valid held.
module mem_x_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int WIDTH   = 64,
    parameter int LENGTH  = 4096,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_write,
    input  logic [NUM_REQ-1:0]       req_last,
    input  logic [NUM_REQ*32-1:0]    req_addr,
    input  logic [NUM_REQ*WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic                     rsp_err,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     mem_write_en,
    output logic [31:0]              mem_addr,
    output logic [WIDTH-1:0]         mem_data_in,
    input  logic [WIDTH-1:0]         mem_data_out
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   owner_q, owner_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   win_idx, probe, gnt_idx;
    logic             found, gnt_vld;
    logic             sel_write, sel_last, in_range;
    logic [31:0]      sel_addr;
    logic             rd_issue, rd_err;
    logic [WIDTH-1:0] rsp_data_q;

    logic [31:0]      addr_a  [NUM_REQ];
    logic [WIDTH-1:0] wdata_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_a[g]  = req_addr[32*g +: 32];
        assign wdata_a[g] = req_wdata[WIDTH*g +: WIDTH];
    end

    function automatic logic [IDW-1:0] inc_wrap(input logic [IDW-1:0] idx);
        if (int'(idx) == NUM_REQ - 1) return '0;
        return idx + 1'b1;
    endfunction

    // Owner selection and lock/pointer next-state; grant is suppressed while reset is asserted.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        found    = 1'b0;
        win_idx  = rr_ptr_q;
        probe    = rr_ptr_q;
        gnt_vld  = 1'b0;
        gnt_idx  = owner_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[probe]) begin
                found   = 1'b1;
                win_idx = probe;
            end
            probe = inc_wrap(probe);
        end
        case (state_q)
            IDLE: begin
                gnt_vld = found;
                gnt_idx = win_idx;
            end
            LOCKED: begin
                gnt_vld = req_valid[owner_q];
                gnt_idx = owner_q;
            end
            default: ;
        endcase
        if (!rst_n) gnt_vld = 1'b0;
        if (gnt_vld) begin
            if (req_last[gnt_idx]) begin
                state_d  = IDLE;
                rr_ptr_d = inc_wrap(gnt_idx);
            end else begin
                state_d = LOCKED;
                owner_d = gnt_idx;
            end
        end
    end

    // Memory command and grant driven straight from the granted requester's inputs.
    always_comb begin
        sel_write    = req_write[gnt_idx];
        sel_last     = req_last[gnt_idx];
        sel_addr     = addr_a[gnt_idx];
        in_range     = sel_addr < 32'(LENGTH);
        req_ready    = '0;
        mem_write_en = 1'b0;
        mem_addr     = '0;
        mem_data_in  = '0;
        rd_issue     = 1'b0;
        rd_err       = 1'b0;
        if (gnt_vld) begin
            req_ready[gnt_idx] = 1'b1;
            mem_write_en       = sel_write & in_range;
            // Out-of-range reads are pointed at word 0 so the memory never sees a bad address.
            mem_addr           = (!sel_write && !in_range) ? 32'd0 : sel_addr;
            mem_data_in        = wdata_a[gnt_idx];
            rd_issue           = ~sel_write;
            rd_err             = ~sel_write & ~in_range;
        end
    end

    // Arbitration state: lock owner and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Response tracking: flag the read issued last cycle and hold the last returned data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= '0;
            rsp_err    <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            rsp_valid <= rd_issue ? req_ready : '0;
            rsp_err   <= rd_err;
            if (|rsp_valid) rsp_data_q <= rsp_data;
        end
    end

    // Memory output is only valid in the response cycle, so pass it through then and hold it afterwards.
    assign rsp_data = (|rsp_valid) ? (rsp_err ? '0 : mem_data_out) : rsp_data_q;

    // sel_last is consumed through req_last in the next-state logic; kept for readability of the command path.
    logic unused_sel_last;
    assign unused_sel_last = sel_last;

endmodule

// File: tb/tb_mem_x_arbiter.sv
module tb_mem_x_arbiter;
    localparam int NR  = 3;
    localparam int W   = 64;
    localparam int LEN = 4096;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_valid, req_write, req_last, req_ready, rsp_valid;
    logic [NR*32-1:0] req_addr;
    logic [NR*W-1:0] req_wdata;
    logic            rsp_err;
    logic [W-1:0]    rsp_data;
    logic            mem_write_en;
    logic [31:0]     mem_addr;
    logic [W-1:0]    mem_data_in, mem_data_out;

    logic [W-1:0]    mem [LEN];
    logic            bk_we;
    logic [11:0]     bk_addr;
    logic [W-1:0]    bk_data;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] rr_dat [3];

    mem_x_arbiter #(.NUM_REQ(NR), .WIDTH(W), .LENGTH(LEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_last(req_last),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
        .mem_write_en(mem_write_en), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    // Single-port memory with registered read data and a back-door preload port.
    always @(posedge clk) begin
        if (bk_we) mem[bk_addr] <= bk_data;
        else if (mem_write_en) mem[mem_addr[11:0]] <= mem_data_in;
        mem_data_out <= mem[mem_addr[11:0]];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drv(input int i, input logic v, input logic w, input logic l,
                       input logic [31:0] a, input logic [63:0] d);
        req_valid[i]          = v;
        req_write[i]          = w;
        req_last[i]           = l;
        req_addr[32*i +: 32]  = a;
        req_wdata[W*i +: W]   = d;
    endtask

    task automatic idle_all();
        req_valid = '0;
        req_write = '0;
        req_last  = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic preload(input logic [11:0] a, input logic [63:0] d);
        bk_we   = 1'b1;
        bk_addr = a;
        bk_data = d;
        nxt();
        bk_we   = 1'b0;
    endtask

    initial begin
        int beat;
        rr_dat[0] = 64'h1111; rr_dat[1] = 64'h2222; rr_dat[2] = 64'h3333;
        rst_n = 1'b0;
        bk_we = 1'b0; bk_addr = '0; bk_data = '0;
        idle_all();
        for (int i = 0; i < NR; i++) drv(i, 1'b1, 1'b0, 1'b1, 32'd16, 64'd0);

        // Reset state, with requests pending
        smp();
        chk("rst_ready", req_ready, 3'b000);
        chk("rst_rsp_valid", rsp_valid, 3'b000);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_mem_we", mem_write_en, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        idle_all();
        nxt();
        preload(12'd2048, 64'h0102030405060708);
        preload(12'd16, rr_dat[0]);
        preload(12'd17, rr_dat[1]);
        preload(12'd18, rr_dat[2]);
        rst_n = 1'b1;

        // Single read from requester 1
        drv(1, 1'b1, 1'b0, 1'b1, 32'd2048, 64'd0);
        smp();
        chk("rd_ready", req_ready, 3'b010);
        chk("rd_mem_addr", mem_addr, 32'd2048);
        chk("rd_mem_we", mem_write_en, 1'b0);
        nxt();
        idle_all();
        smp();
        chk("rd_rsp_valid", rsp_valid, 3'b010);
        chk("rd_rsp_data", rsp_data, 64'h0102030405060708);
        chk("rd_rsp_err", rsp_err, 1'b0);

        // Round-robin from reset with all three requesters reading
        nxt();
        rst_n = 1'b0;
        nxt();
        rst_n = 1'b1;
        for (int i = 0; i < NR; i++) drv(i, 1'b1, 1'b0, 1'b1, 32'(16 + i), 64'd0);
        for (int c = 0; c < 6; c++) begin
            smp();
            chk($sformatf("rr_ready_%0d", c), req_ready, 64'(1 << (c % 3)));
            chk($sformatf("rr_rsp_valid_%0d", c), rsp_valid, (c == 0) ? 64'd0 : 64'(1 << ((c - 1) % 3)));
            if (c > 0) chk($sformatf("rr_rsp_data_%0d", c), rsp_data, rr_dat[(c - 1) % 3]);
            nxt();
        end
        idle_all();
        smp();
        chk("rr_rsp_valid_last", rsp_valid, 3'b100);
        chk("rr_rsp_data_last", rsp_data, rr_dat[2]);

        // Burst lock: req 0 writes 0..3 with a 2-cycle gap, reqs 1 and 2 competing
        nxt();
        drv(1, 1'b1, 1'b0, 1'b1, 32'd16, 64'd0);
        drv(2, 1'b1, 1'b0, 1'b1, 32'd17, 64'd0);
        beat = 0;
        for (int c = 0; c < 6; c++) begin
            if (c == 2 || c == 3) drv(0, 1'b0, 1'b1, 1'b0, 32'd0, 64'd0);
            else drv(0, 1'b1, 1'b1, (beat == 3), 32'(beat), 64'hB0 + 64'(beat));
            smp();
            if (c == 2 || c == 3) begin
                chk($sformatf("bl_gap_ready_%0d", c), req_ready, 3'b000);
                chk($sformatf("bl_gap_we_%0d", c), mem_write_en, 1'b0);
            end else begin
                chk($sformatf("bl_ready_%0d", c), req_ready, 3'b001);
                chk($sformatf("bl_we_%0d", c), mem_write_en, 1'b1);
                chk($sformatf("bl_addr_%0d", c), mem_addr, 64'(beat));
                chk($sformatf("bl_wdata_%0d", c), mem_data_in, 64'hB0 + 64'(beat));
                beat++;
            end
            nxt();
        end
        drv(0, 1'b0, 1'b0, 1'b0, 32'd0, 64'd0);
        smp();
        chk("bl_next_ready", req_ready, 3'b010);
        nxt();
        idle_all();
        smp();
        chk("bl_rsp_valid", rsp_valid, 3'b010);
        chk("bl_rsp_data", rsp_data, rr_dat[0]);
        chk("bl_mem0", mem[0], 64'hB0);
        chk("bl_mem3", mem[3], 64'hB3);

        // Write then read back-to-back from requester 2
        nxt();
        drv(2, 1'b1, 1'b1, 1'b1, 32'd100, 64'hDEADBEEF00000001);
        smp();
        chk("wr_ready", req_ready, 3'b100);
        chk("wr_we", mem_write_en, 1'b1);
        nxt();
        drv(2, 1'b1, 1'b0, 1'b1, 32'd100, 64'd0);
        smp();
        chk("wtr_ready", req_ready, 3'b100);
        chk("wtr_we", mem_write_en, 1'b0);
        chk("wtr_no_rsp", rsp_valid, 3'b000);
        nxt();
        idle_all();
        smp();
        chk("wtr_rsp_valid", rsp_valid, 3'b100);
        chk("wtr_rsp_data", rsp_data, 64'hDEADBEEF00000001);
        nxt();
        smp();
        chk("hold_rsp_valid", rsp_valid, 3'b000);
        chk("hold_rsp_data", rsp_data, 64'hDEADBEEF00000001);

        // Out-of-range write and read
        nxt();
        drv(0, 1'b1, 1'b1, 1'b1, 32'd4096, 64'hFFFF);
        smp();
        chk("oor_wr_ready", req_ready, 3'b001);
        chk("oor_wr_we", mem_write_en, 1'b0);
        nxt();
        drv(0, 1'b1, 1'b0, 1'b1, 32'd5000, 64'd0);
        smp();
        chk("oor_rd_ready", req_ready, 3'b001);
        chk("oor_rd_addr", mem_addr, 32'd0);
        nxt();
        idle_all();
        smp();
        chk("oor_rsp_valid", rsp_valid, 3'b001);
        chk("oor_rsp_err", rsp_err, 1'b1);
        chk("oor_rsp_data", rsp_data, 64'd0);
        chk("oor_mem0", mem[0], 64'hB0);
        nxt();
        smp();
        chk("oor_err_clear", rsp_err, 1'b0);

        // Reset during a locked read burst with a read in flight
        nxt();
        drv(0, 1'b1, 1'b0, 1'b1, 32'd17, 64'd0);
        drv(1, 1'b1, 1'b0, 1'b0, 32'd16, 64'd0);
        drv(2, 1'b1, 1'b0, 1'b1, 32'd18, 64'd0);
        smp();
        chk("mr_ready", req_ready, 3'b010);
        nxt();
        rst_n = 1'b0;
        #1;
        chk("mr_rst_rsp_valid", rsp_valid, 3'b000);
        chk("mr_rst_ready", req_ready, 3'b000);
        chk("mr_rst_rsp_data", rsp_data, 64'd0);
        chk("mr_rst_mem_addr", mem_addr, 32'd0);
        drv(1, 1'b1, 1'b0, 1'b1, 32'd16, 64'd0);
        nxt();
        rst_n = 1'b1;
        smp();
        chk("mr_post_ready", req_ready, 3'b001);
        chk("mr_post_rsp_valid", rsp_valid, 3'b000);
        nxt();
        idle_all();
        smp();
        chk("mr_post_rsp", rsp_valid, 3'b001);
        chk("mr_post_data", rsp_data, rr_dat[1]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
